ldpc_ber_tester_frame_gen: RTL

LDPC_BER_TESTER_FRAME_GEN -- requirements
Module: ldpc_ber_tester_frame_gen

---
 rtl/ldpc_ber_tester_frame_gen.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/ldpc_ber_tester_frame_gen.sv
// rtl/ldpc_ber_tester_frame_gen.sv - LDPC BER tester frame generator (AXI-Stream master)
//
// Emits frames of frame_bits bits as 128-bit beats toward a decoder / BER counter.
// A run is started with start, lasts num_frames frames (0 = until stop) and ends
// only on a frame boundary, so no partial frame is ever emitted.
//
// Ports:
//   clk, resetn                       clock, asynchronous active-low reset
//   start, stop                       run request / abort request (frame boundary)
//   frame_bits, num_frames            run configuration, sampled on accepted start
//   m_axis_tdata/tvalid/tready/tlast  stream toward the decoder
//   last_mask                         valid-bit mask of the final beat of each frame
//   busy, done, frames_sent           run status
//
// Macro LDPC_BER_TESTER_FRAME_GEN_PRBS_EN: when defined, tdata carries PRBS31
// (x^31+x^28+1, LSB first); otherwise tdata is the all-zero codeword.
module ldpc_ber_tester_frame_gen #(
    parameter int DATA_WIDTH      = 128,
    parameter int FRAME_CNT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       start,
    input  logic                       stop,
    input  logic [15:0]                frame_bits,
    input  logic [FRAME_CNT_WIDTH-1:0] num_frames,
    output logic [DATA_WIDTH-1:0]      m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [DATA_WIDTH-1:0]      last_mask,
    output logic                       busy,
    output logic                       done,
    output logic [FRAME_CNT_WIDTH-1:0] frames_sent
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                     state_q, state_d;
    logic [9:0]                 beats_q, beats_d;
    logic [9:0]                 beat_cnt_q, beat_cnt_d;
    logic [FRAME_CNT_WIDTH-1:0] num_frames_q, num_frames_d;
    logic [FRAME_CNT_WIDTH-1:0] frames_sent_q, frames_sent_d;
    logic [FRAME_CNT_WIDTH-1:0] frames_inc;
    logic [DATA_WIDTH-1:0]      last_mask_q, last_mask_d;
    logic                       tvalid_q, tvalid_d;
    logic                       done_q, done_d;

    logic                       accept_start;
    logic                       xfer;
    logic                       at_last;
    logic                       final_frame;
    logic [9:0]                 start_beats;
    logic [DATA_WIDTH-1:0]      start_mask;
    logic [DATA_WIDTH-1:0]      one_w;

    assign accept_start = (state_q == IDLE) && start;
    assign xfer         = tvalid_q && m_axis_tready;
    assign at_last      = (beat_cnt_q == beats_q - 10'd1);
    assign frames_inc   = frames_sent_q + {{(FRAME_CNT_WIDTH-1){1'b0}}, 1'b1};
    // The frame that is completing is the last of a bounded run.
    assign final_frame  = (num_frames_q != '0) && (frames_inc == num_frames_q);

    // ceil(frame_bits/128); a zero length is treated as one full beat.
    assign start_beats = (frame_bits == 16'd0) ? 10'd1
                       : {1'b0, frame_bits[15:7]} + {9'd0, |frame_bits[6:0]};
    assign one_w       = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    assign start_mask  = (frame_bits[6:0] == 7'd0) ? {DATA_WIDTH{1'b1}}
                       : (one_w << frame_bits[6:0]) - one_w;

    always_comb begin
        state_d       = state_q;
        beats_d       = beats_q;
        beat_cnt_d    = beat_cnt_q;
        num_frames_d  = num_frames_q;
        frames_sent_d = frames_sent_q;
        last_mask_d   = last_mask_q;
        tvalid_d      = tvalid_q;
        done_d        = 1'b0;

        if (xfer) begin
            if (at_last) begin
                beat_cnt_d    = 10'd0;
                frames_sent_d = frames_inc;
            end else begin
                beat_cnt_d = beat_cnt_q + 10'd1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = RUN;
                    tvalid_d      = 1'b1;
                    beat_cnt_d    = 10'd0;
                    frames_sent_d = '0;
                    beats_d       = start_beats;
                    last_mask_d   = start_mask;
                    num_frames_d  = num_frames;
                end
            end
            RUN: begin
                // Frame boundary reached with a reason to end: nothing left in flight.
                if (xfer && at_last && (stop || final_frame)) begin
                    state_d  = DRAIN;
                    tvalid_d = 1'b0;
                end else if (stop) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!tvalid_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (xfer && at_last) begin
                    state_d  = IDLE;
                    tvalid_d = 1'b0;
                    done_d   = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                tvalid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            beats_q       <= 10'd1;
            beat_cnt_q    <= 10'd0;
            num_frames_q  <= '0;
            frames_sent_q <= '0;
            last_mask_q   <= {DATA_WIDTH{1'b1}};
            tvalid_q      <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            beats_q       <= beats_d;
            beat_cnt_q    <= beat_cnt_d;
            num_frames_q  <= num_frames_d;
            frames_sent_q <= frames_sent_d;
            last_mask_q   <= last_mask_d;
            tvalid_q      <= tvalid_d;
            done_q        <= done_d;
        end
    end

`ifdef LDPC_BER_TESTER_FRAME_GEN_PRBS_EN
    localparam logic [30:0] PRBS_SEED = 31'h7FFFFFFF;

    // Runs the generator DATA_WIDTH steps; returns {new state, bits in order}.
    // State bit 0 is the most recent output bit.
    function automatic logic [DATA_WIDTH+30:0] prbs_block(input logic [30:0] seed);
        logic [30:0]           s;
        logic [DATA_WIDTH-1:0] d;
        logic                  b;
        s = seed;
        d = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            b    = s[30] ^ s[27];
            d[i] = b;
            s    = {s[29:0], b};
        end
        return {s, d};
    endfunction

    logic [30:0]            prbs_q, prbs_d;
    logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
    logic [DATA_WIDTH+30:0] seed_blk, next_blk;

    assign seed_blk = prbs_block(PRBS_SEED);
    assign next_blk = prbs_block(prbs_q);

    // prbs_q is always the state just past the beat currently presented.
    always_comb begin
        prbs_d  = prbs_q;
        tdata_d = tdata_q;
        if (accept_start) begin
            {prbs_d, tdata_d} = seed_blk;
        end else if (xfer) begin
            {prbs_d, tdata_d} = next_blk;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prbs_q  <= PRBS_SEED;
            tdata_q <= '0;
        end else begin
            prbs_q  <= prbs_d;
            tdata_q <= tdata_d;
        end
    end

    assign m_axis_tdata = tdata_q;
`else
    assign m_axis_tdata = '0;
`endif

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tvalid_q && at_last;
    assign last_mask     = last_mask_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign frames_sent   = frames_sent_q;

endmodule
